// File: rtl/ntt_pkg.sv
// Shared definitions for the 16-point NTT control path.
//   N, LOGN        transform size and number of butterfly stages
//   BU_LAT_DEFAULT butterfly pipeline latency (bu_en to valid result)
//   state_t        sequencer state encoding
//   bitrev()       bit-reversal of a LOGN-bit load index
package ntt_pkg;

    localparam int N              = 16;
    localparam int LOGN           = 4;
    localparam int BU_LAT_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_OUT     = 2'd3
    } state_t;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        r = '0;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = v[LOGN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_stage_timer.sv
// Butterfly stage timer: each stage lasts BU_LAT+1 cycles.
//   clk, rst   clock, asynchronous active-low reset
//   launch     first compute cycle follows (loads stage 0 / launch pulse)
//   active     sequencer is in COMPUTE (advances the timer)
//   bu_en      registered; high in the first cycle of each stage
//   capture    registered; high in the last cycle of each stage
//   stage      registered current stage index
//   last       capture cycle of the final stage (combinational, internal use)
module ntt_stage_timer
    import ntt_pkg::*;
#(
    parameter int BU_LAT = BU_LAT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       launch,
    input  logic       active,
    output logic       bu_en,
    output logic       capture,
    output logic [2:0] stage,
    output logic       last
);

    // Phase is 6 bits wide: the total compute length is bounded to 64 cycles,
    // so a single stage can never need more.
    localparam logic [5:0] PHASE_LAST = 6'(BU_LAT);
    localparam logic [2:0] STAGE_LAST = 3'(LOGN - 1);
    localparam logic       CAP_AT_0   = (BU_LAT == 0);

    logic [5:0] phase_reg;
    logic [2:0] stage_reg;
    logic       bu_en_reg;
    logic       capture_reg;

    // Outputs are computed one cycle ahead so they are valid, registered,
    // in the cycle they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_reg   <= '0;
            stage_reg   <= '0;
            bu_en_reg   <= 1'b0;
            capture_reg <= 1'b0;
        end else if (launch) begin
            phase_reg   <= '0;
            stage_reg   <= '0;
            bu_en_reg   <= 1'b1;
            capture_reg <= CAP_AT_0;
        end else if (active) begin
            if (phase_reg == PHASE_LAST) begin
                phase_reg <= '0;
                if (stage_reg == STAGE_LAST) begin
                    stage_reg   <= '0;
                    bu_en_reg   <= 1'b0;
                    capture_reg <= 1'b0;
                end else begin
                    stage_reg   <= stage_reg + 3'd1;
                    bu_en_reg   <= 1'b1;
                    capture_reg <= CAP_AT_0;
                end
            end else begin
                phase_reg   <= phase_reg + 6'd1;
                bu_en_reg   <= 1'b0;
                capture_reg <= ((phase_reg + 6'd1) == PHASE_LAST);
            end
        end
    end

    assign bu_en   = bu_en_reg;
    assign capture = capture_reg;
    assign stage   = stage_reg;
    assign last    = active && capture_reg && (stage_reg == STAGE_LAST);

endmodule

// File: rtl/ntt_sequencer.sv
// Control FSM for the 16-point NTT datapath: serial load with bit-reversed
// addressing, LOGN butterfly stages, then valid/ready result handoff.
//   clk, rst             clock, asynchronous active-low reset
//   start                begin a transform (only honoured in IDLE)
//   in_valid / in_ready  serial coefficient handshake
//   load_en, load_addr   load-register write strobe and bit-reversed index
//   switch               operand mux: 0 = load registers, 1 = feedback
//   bu_en, capture       butterfly launch pulse / result latch
//   stage, data_loop     stage index and compute-cycle (twiddle) counter
//   out_valid/out_ready  result handshake
//   busy, done           not-IDLE flag, one-cycle completion pulse
module ntt_sequencer
    import ntt_pkg::*;
#(
    parameter int BU_LAT = BU_LAT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            load_en,
    output logic [LOGN-1:0] load_addr,
    output logic            switch,
    output logic            bu_en,
    output logic            capture,
    output logic [2:0]      stage,
    output logic [5:0]      data_loop,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            done
);

    if (LOGN * (BU_LAT + 1) > 64) begin : g_bad_timing
        $error("ntt_sequencer: LOGN*(BU_LAT+1) exceeds 64, data_loop would wrap");
    end

    localparam logic [LOGN-1:0] CNT_LAST = LOGN'(N - 1);
    localparam logic [LOGN-1:0] CNT_ONE  = LOGN'(1);

    state_t          state_reg;
    logic [LOGN-1:0] cnt_reg;
    logic            in_ready_reg;
    logic            switch_reg;
    logic [5:0]      data_loop_reg;
    logic            out_valid_reg;
    logic            busy_reg;
    logic            done_reg;

    logic accept;
    logic launch;
    logic active;
    logic last_capture;

    // in_ready_reg is only ever set in LOAD, so it doubles as the state gate.
    assign accept = in_valid && in_ready_reg;
    assign launch = accept && (cnt_reg == CNT_LAST);
    assign active = (state_reg == ST_COMPUTE);

    ntt_stage_timer #(
        .BU_LAT(BU_LAT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .launch (launch),
        .active (active),
        .bu_en  (bu_en),
        .capture(capture),
        .stage  (stage),
        .last   (last_capture)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b0;
            switch_reg    <= 1'b0;
            data_loop_reg <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg    <= ST_LOAD;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        cnt_reg <= cnt_reg + CNT_ONE;  // wraps to 0 after N-1
                        if (cnt_reg == CNT_LAST) begin
                            state_reg     <= ST_COMPUTE;
                            in_ready_reg  <= 1'b0;
                            data_loop_reg <= '0;
                            switch_reg    <= 1'b0;
                        end
                    end
                end
                ST_COMPUTE: begin
                    data_loop_reg <= data_loop_reg + 6'd1;
                    // From stage 1 on the butterflies read their own feedback.
                    if (capture && !last_capture) begin
                        switch_reg <= 1'b1;
                    end
                    if (last_capture) begin
                        state_reg     <= ST_OUT;
                        out_valid_reg <= 1'b1;
                        data_loop_reg <= '0;
                        switch_reg    <= 1'b0;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_reg     <= ST_IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign load_en   = accept;
    assign load_addr = bitrev(cnt_reg);
    assign switch    = switch_reg;
    assign data_loop = data_loop_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_ntt_sequencer.sv
module tb_ntt_sequencer;
    import ntt_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic            in_ready;
    logic            load_en;
    logic [LOGN-1:0] load_addr;
    logic            switch;
    logic            bu_en;
    logic            capture;
    logic [2:0]      stage;
    logic [5:0]      data_loop;
    logic            out_valid;
    logic            busy;
    logic            done;

    int vectors = 0;
    int errors = 0;
    int load_pulses = 0;

    localparam int BU_LAT   = BU_LAT_DEFAULT;
    localparam int STAGE_CY = BU_LAT + 1;
    localparam int COMP_CY  = LOGN * STAGE_CY;

    ntt_sequencer #(.BU_LAT(BU_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .load_en(load_en), .load_addr(load_addr),
        .switch(switch), .bu_en(bu_en), .capture(capture), .stage(stage),
        .data_loop(data_loop), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && load_en) load_pulses++;
    end

    logic [20:0] all_out;
    assign all_out = {in_ready, load_en, load_addr, switch, bu_en, capture,
                      stage, data_loop, out_valid, busy, done};

    // Reference bit reversal by arithmetic digit extraction.
    function automatic int rev_index(input int v);
        int r = 0;
        int x = v;
        for (int i = 0; i < LOGN; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transform. Per-cycle expectations come from the schedule rules:
    // N accepts in bit-reversed order, then LOGN stages of BU_LAT+1 cycles.
    task automatic do_transform(input int id, input bit skip_start, input bit rnd,
                                input int gap_at, input int gap_len, input int bp,
                                input bit start_in_compute, input bit start_at_done);
        int k = 0;
        int cycles = 0;
        int gap_left = gap_len;
        logic [14:0] exp_c, act_c;
        load_pulses = 0;
        if (!skip_start) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        while (k < N) begin
            if (cycles++ > 300) begin
                vectors++; errors++;
                $display("FAIL load_timeout: accepted %0d words, required %0d", k, N);
                in_valid = 1'b0;
                return;
            end
            if (k == gap_at && gap_left > 0) begin
                in_valid = 1'b0;
                gap_left--;
            end else begin
                in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            #1;
            vectors++;
            if ({in_ready, busy, load_en, load_addr, out_valid, bu_en} !==
                {1'b1, 1'b1, in_valid, LOGN'(rev_index(k)), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL load_k%0d: rdy=%b busy=%b en=%b addr=%0d, required en=%b addr=%0d",
                         k, in_ready, busy, load_en, load_addr, in_valid, rev_index(k));
            end
            step();
            if (in_valid) k++;
        end
        in_valid = 1'b0;
        for (int c = 0; c < COMP_CY; c++) begin
            start = (start_in_compute && c == 4);
            exp_c = {1'b0, 1'b1, (c % STAGE_CY) == 0, (c % STAGE_CY) == BU_LAT,
                     3'(c / STAGE_CY), (c / STAGE_CY) != 0, 6'(c), 1'b0};
            act_c = {in_ready, busy, bu_en, capture, stage, switch, data_loop, out_valid};
            vectors++;
            if (act_c !== exp_c) begin
                errors++;
                $display("FAIL compute_c%0d: got %h required %h", c, act_c, exp_c);
            end
            step();
        end
        start = 1'b0;
        for (int b = 0; b < bp; b++) begin
            out_ready = 1'b0;
            vectors++;
            if ({out_valid, done, busy} !== 3'b101) begin
                errors++;
                $display("FAIL backpressure_b%0d: valid/done/busy=%b required 101",
                         b, {out_valid, done, busy});
            end
            step();
        end
        out_ready = 1'b1;
        vectors++;
        if ({out_valid, done} !== 2'b10) begin
            errors++;
            $display("FAIL out_first: valid/done=%b required 10", {out_valid, done});
        end
        step();
        out_ready = 1'b0;
        vectors++;
        if ({done, busy, out_valid, in_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL done_cycle: done/busy/valid/rdy=%b required 1000",
                     {done, busy, out_valid, in_ready});
        end
        if (start_at_done) start = 1'b1;
        step();
        start = 1'b0;
        vectors++;
        if ({done, busy, in_ready} !== {1'b0, start_at_done, start_at_done}) begin
            errors++;
            $display("FAIL after_done: done/busy/rdy=%b required 0%b%b",
                     {done, busy, in_ready}, start_at_done, start_at_done);
        end
        if (!start_at_done) begin
            vectors++;
            if (load_pulses !== N) begin
                errors++;
                $display("FAIL load_pulses: got %0d required %0d", load_pulses, N);
            end
        end
        $display("transform %0d: load %0d cycles, backpressure %0d, load_en pulses %0d",
                 id, cycles, bp, load_pulses);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (all_out !== '0) begin
                errors++;
                $display("FAIL reset_hold_%0d: outputs=%h required 0", i, all_out);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if (all_out !== '0) begin
                errors++;
                $display("FAIL idle_%0d: outputs=%h required 0", i, all_out);
            end
        end
        $display("reset: 3 cycles held, 10 idle cycles observed");
    endtask

    task automatic test_full();
        do_transform(1, 1'b0, 1'b0, -1, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_load_stall();
        do_transform(2, 1'b0, 1'b0, 7, 5, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_transform(3, 1'b0, 1'b1, -1, 0, 20, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_transform(4, 1'b0, 1'b1, -1, 0, 1, 1'b1, 1'b1);
        do_transform(5, 1'b1, 1'b1, -1, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 3; t++) begin
            do_transform(6 + t, 1'b0, 1'b1, int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
                         1'b0, 1'b0);
        end
    endtask

    task automatic test_abort();
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) step();
        in_valid = 1'b0;
        // Land in the second cycle of stage 2.
        for (int c = 0; c < 2 * STAGE_CY + 1; c++) step();
        vectors++;
        if (stage !== 3'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup: stage=%0d busy=%b required 2/1", stage, busy);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL abort_async: outputs=%h required 0", all_out);
        end
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (all_out !== '0) begin
                errors++;
                $display("FAIL abort_idle_%0d: outputs=%h required 0", i, all_out);
            end
        end
        $display("abort: reset in stage 2, no done pulse afterwards");
        do_transform(10, 1'b0, 1'b0, -1, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full();
        test_load_stall();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
